// File: rtl/branch_issue_queue.sv
// Branch reservation station: age-ordered wakeup/select feeding one registered result slot.
// Define BRANCH_ISSUE_QUEUE_CDB_BYPASS_EN to capture a same-cycle CDB broadcast at allocation.
module branch_issue_queue #(
  parameter int DEPTH       = 8,
  parameter int XLEN        = 64,
  parameter int ROB_IDX_LEN = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         flush_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [2:0]                   issue_type_i,
  input  logic                         issue_rs1_ready_i,
  input  logic [ROB_IDX_LEN-1:0]       issue_rs1_idx_i,
  input  logic [XLEN-1:0]              issue_rs1_value_i,
  input  logic                         issue_rs2_ready_i,
  input  logic [ROB_IDX_LEN-1:0]       issue_rs2_idx_i,
  input  logic [XLEN-1:0]              issue_rs2_value_i,
  input  logic [XLEN-1:0]              issue_imm_i,
  input  logic [ROB_IDX_LEN-1:0]       issue_dest_idx_i,
  input  logic [XLEN-1:0]              issue_pc_i,
  input  logic [XLEN-1:0]              issue_pred_target_i,
  input  logic                         issue_pred_taken_i,
  input  logic                         cdb_valid_i,
  input  logic [ROB_IDX_LEN-1:0]       cdb_idx_i,
  input  logic [XLEN-1:0]              cdb_value_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [ROB_IDX_LEN-1:0]       res_idx_o,
  output logic [XLEN-1:0]              res_pc_o,
  output logic [XLEN-1:0]              res_target_o,
  output logic                         res_taken_o,
  output logic                         res_mispredict_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Handshakes: an issue is taken when issue_valid_i && issue_ready_o; a result is
  // consumed when res_valid_o && res_ready_i, and res_* hold while valid && !ready.
  logic [DEPTH-1:0]       valid_q, rs1_rdy_q, rs2_rdy_q, pred_taken_q;
  logic [2:0]             type_q     [DEPTH];
  logic [ROB_IDX_LEN-1:0] rs1_idx_q  [DEPTH];
  logic [ROB_IDX_LEN-1:0] rs2_idx_q  [DEPTH];
  logic [ROB_IDX_LEN-1:0] dest_q     [DEPTH];
  logic [XLEN-1:0]        rs1_val_q  [DEPTH];
  logic [XLEN-1:0]        rs2_val_q  [DEPTH];
  logic [XLEN-1:0]        imm_q      [DEPTH];
  logic [XLEN-1:0]        pc_q       [DEPTH];
  logic [XLEN-1:0]        pred_tgt_q [DEPTH];
  // older_q[i][j] set means entry j was accepted before entry i.
  logic [DEPTH-1:0]       older_q    [DEPTH];

  logic                   res_valid_q, res_taken_q, res_mispredict_q;
  logic [ROB_IDX_LEN-1:0] res_idx_q;
  logic [XLEN-1:0]        res_pc_q, res_target_q;

  logic [CW-1:0]          count;
  logic [DEPTH-1:0]       ready_vec;
  logic                   alloc_found, sel_found, do_alloc, do_sel, load_out, taken;
  logic [IW-1:0]          alloc_idx, sel_idx;
  logic                   new_rs1_rdy, new_rs2_rdy;
  logic [XLEN-1:0]        new_rs1_val, new_rs2_val, op_a, op_b, sel_pc, br_target;

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + CW'(valid_q[i]);
  end

  assign count_o       = count;
  assign issue_ready_o = (count < CW'(DEPTH));
  assign do_alloc      = issue_valid_i && issue_ready_o && !flush_i;
  assign ready_vec     = valid_q & rs1_rdy_q & rs2_rdy_q;
  assign load_out      = !res_valid_q || res_ready_i;
  assign do_sel        = load_out && sel_found;

  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!alloc_found && !valid_q[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = IW'(i);
      end
    end
  end

  // The oldest ready entry is the one with no older ready entry.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && ready_vec[i] && ((ready_vec & older_q[i]) == '0)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

`ifdef BRANCH_ISSUE_QUEUE_CDB_BYPASS_EN
  logic rs1_hit, rs2_hit;
  assign rs1_hit     = cdb_valid_i && !issue_rs1_ready_i && (cdb_idx_i == issue_rs1_idx_i);
  assign rs2_hit     = cdb_valid_i && !issue_rs2_ready_i && (cdb_idx_i == issue_rs2_idx_i);
  assign new_rs1_rdy = issue_rs1_ready_i || rs1_hit;
  assign new_rs2_rdy = issue_rs2_ready_i || rs2_hit;
  assign new_rs1_val = rs1_hit ? cdb_value_i : issue_rs1_value_i;
  assign new_rs2_val = rs2_hit ? cdb_value_i : issue_rs2_value_i;
`else
  assign new_rs1_rdy = issue_rs1_ready_i;
  assign new_rs2_rdy = issue_rs2_ready_i;
  assign new_rs1_val = issue_rs1_value_i;
  assign new_rs2_val = issue_rs2_value_i;
`endif

  always_comb begin
    op_a      = rs1_val_q[sel_idx];
    op_b      = rs2_val_q[sel_idx];
    sel_pc    = pc_q[sel_idx];
    br_target = sel_pc + imm_q[sel_idx];
    case (type_q[sel_idx])
      3'd0:    taken = (op_a == op_b);
      3'd1:    taken = (op_a != op_b);
      3'd4:    taken = ($signed(op_a) < $signed(op_b));
      3'd5:    taken = !($signed(op_a) < $signed(op_b));
      3'd6:    taken = (op_a < op_b);
      3'd7:    taken = !(op_a < op_b);
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_alloc && (alloc_idx == IW'(i))) begin
          valid_q[i]      <= 1'b1;
          type_q[i]       <= issue_type_i;
          rs1_rdy_q[i]    <= new_rs1_rdy;
          rs1_idx_q[i]    <= issue_rs1_idx_i;
          rs1_val_q[i]    <= new_rs1_val;
          rs2_rdy_q[i]    <= new_rs2_rdy;
          rs2_idx_q[i]    <= issue_rs2_idx_i;
          rs2_val_q[i]    <= new_rs2_val;
          imm_q[i]        <= issue_imm_i;
          dest_q[i]       <= issue_dest_idx_i;
          pc_q[i]         <= issue_pc_i;
          pred_tgt_q[i]   <= issue_pred_target_i;
          pred_taken_q[i] <= issue_pred_taken_i;
          older_q[i]      <= valid_q;
        end else begin
          if (do_sel && (sel_idx == IW'(i))) valid_q[i] <= 1'b0;
          if (cdb_valid_i && valid_q[i] && !rs1_rdy_q[i] && (rs1_idx_q[i] == cdb_idx_i)) begin
            rs1_rdy_q[i] <= 1'b1;
            rs1_val_q[i] <= cdb_value_i;
          end
          if (cdb_valid_i && valid_q[i] && !rs2_rdy_q[i] && (rs2_idx_q[i] == cdb_idx_i)) begin
            rs2_rdy_q[i] <= 1'b1;
            rs2_val_q[i] <= cdb_value_i;
          end
          // A new arrival is younger than everyone; this also clears stale bits from the slot's previous owner.
          if (do_alloc) older_q[i][alloc_idx] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      res_valid_q      <= 1'b0;
      res_idx_q        <= '0;
      res_pc_q         <= '0;
      res_target_q     <= '0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
    end else if (load_out) begin
      res_valid_q <= sel_found;
      if (sel_found) begin
        res_idx_q        <= dest_q[sel_idx];
        res_pc_q         <= sel_pc;
        res_target_q     <= taken ? br_target : sel_pc + XLEN'(4);
        res_taken_q      <= taken;
        res_mispredict_q <= (taken != pred_taken_q[sel_idx]) ||
                            (taken && (br_target != pred_tgt_q[sel_idx]));
      end
    end
  end

  assign res_valid_o      = res_valid_q;
  assign res_idx_o        = res_idx_q;
  assign res_pc_o         = res_pc_q;
  assign res_target_o     = res_target_q;
  assign res_taken_o      = res_taken_q;
  assign res_mispredict_o = res_mispredict_q;
endmodule

// File: doc/branch_issue_queue.md
BRANCH_ISSUE_QUEUE -- requirements
Module: branch_issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of queue entries; SHALL be a power of two, at least 2.
REQ-002 Parameter XLEN, default 64, operand and PC width.
REQ-003 Parameter ROB_IDX_LEN, default 6, ROB tag width.
REQ-004 Ports SHALL be exactly the following:
- clk_i  in  1  sole clock, rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- flush_i  in  1  squash all contents.
- issue_valid_i  in  1  / issue_ready_o  out  1  allocation handshake.
- issue_type_i  in  3  funct3 encoding: BEQ=0, BNE=1, BLT=4, BGE=5, BLTU=6, BGEU=7.
- issue_rs1_ready_i  in  1 / issue_rs1_idx_i  in  ROB_IDX_LEN / issue_rs1_value_i  in  XLEN.
- issue_rs2_ready_i  in  1 / issue_rs2_idx_i  in  ROB_IDX_LEN / issue_rs2_value_i  in  XLEN.
- issue_imm_i  in  XLEN  sign-extended offset.
- issue_dest_idx_i  in  ROB_IDX_LEN  ROB tag of the branch.
- issue_pc_i  in  XLEN  branch PC.
- issue_pred_target_i  in  XLEN / issue_pred_taken_i  in  1  prediction.
- cdb_valid_i  in  1 / cdb_idx_i  in  ROB_IDX_LEN / cdb_value_i  in  XLEN  CDB broadcast.
- res_valid_o  out  1 / res_ready_i  in  1  result handshake.
- res_idx_o  out  ROB_IDX_LEN / res_pc_o  out  XLEN / res_target_o  out  XLEN.
- res_taken_o  out  1 / res_mispredict_o  out  1.
- count_o  out  $clog2(DEPTH+1)  valid entries, excluding the output register.

Function
REQ-005 issue_ready_o SHALL be 1 when count_o < DEPTH, from registered state only; it SHALL NOT depend on issue_valid_i.
REQ-006 On issue_valid_i && issue_ready_o && !flush_i, the block SHALL write the lowest-index free entry, and the entry SHALL be valid next cycle.
REQ-007 An entry is ready when both operand flags are set. Each cycle, the oldest ready entry (earliest accepted) SHALL be selected when the output register is empty or res_ready_i=1.
REQ-008 On selection, the block SHALL free the entry and load the output register; res_valid_o SHALL rise the next cycle. The minimum latency from acceptance with both operands ready to res_valid_o is 2 cycles.
REQ-009 Taken SHALL be computed as: BEQ a==b; BNE a!=b; BLT/BGE signed less-than / not less-than; BLTU/BGEU unsigned. Types 2 and 3 SHALL give not-taken.
REQ-010 res_target_o SHALL be pc+imm if taken, else pc+4, modulo 2^XLEN.
REQ-011 res_mispredict_o SHALL be (taken != pred_taken) || (taken && pc+imm != pred_target).
REQ-012 The output register SHALL hold all res_* values stable while res_valid_o && !res_ready_i.
REQ-013 When cdb_valid_i=1, every valid entry with a non-ready operand whose idx equals cdb_idx_i SHALL capture cdb_value_i and set the flag. The entry SHALL be selectable no earlier than the following cycle.
REQ-014 A slot freed in cycle N SHALL NOT be reallocated in cycle N.
REQ-015 Full plus simultaneous selection: issue_ready_o SHALL stay 0 that cycle.
REQ-016 Empty: res_valid_o SHALL fall after the handshake, with no spurious result.
REQ-017 Age order SHALL survive any interleaving of allocation and free; no starvation.
REQ-018 flush_i SHALL take priority over every other event. Next cycle, all entries and the output register SHALL be invalid, count_o=0 and res_valid_o=0, and a same-cycle issue SHALL be dropped.

Reset
REQ-019 While rst_n_i=0 at a clock edge, all entries and the output register SHALL be cleared.
REQ-020 After reset, res_valid_o=0, all res_* outputs=0, count_o=0 and issue_ready_o=1.
REQ-021 Reset mid-operation SHALL discard all held and pending results, with no result emitted afterwards.

Configuration
REQ-022 Macro BRANCH_ISSUE_QUEUE_CDB_BYPASS_EN SHALL control same-cycle capture of CDB values at allocation.
REQ-023 With BRANCH_ISSUE_QUEUE_CDB_BYPASS_EN defined: during allocation, a non-ready issue operand whose idx matches a valid CDB broadcast SHALL be stored ready with cdb_value_i.
REQ-024 Without BRANCH_ISSUE_QUEUE_CDB_BYPASS_EN: issue operand flags and values SHALL be stored verbatim, and upstream SHALL account for same-cycle broadcasts.

Verification
REQ-025 BEQ, rs1=rs2=5, pc=0x1000, imm=0x20, pred taken to 0x1020 -> after 2 cycles res_taken_o=1, res_target_o=0x1020, res_mispredict_o=0.
REQ-026 BLT, rs1=-1, rs2=1 with BLTU identical operands, both pred not-taken -> BLT taken with mispredict=1; BLTU not-taken, target pc+4, mispredict=0.
REQ-027 Fill 8 entries with rs1 waiting on tag 3 -> issue_ready_o=0, count_o=8; CDB tag 3 -> results emerge in acceptance order, one per cycle with res_ready_i=1.
REQ-028 Hold res_ready_i=0 for 5 cycles with 2 ready entries -> res_* stable, count_o=1 after the first selection, no loss.
REQ-029 Flush with 4 entries and a pending result, issue_valid_i=1 same cycle -> next cycle count_o=0, res_valid_o=0.
REQ-030 Issue rs2 non-ready with tag 7 while CDB broadcasts tag 7 -> with the macro, result in 2 cycles; without it, the entry stays waiting.
